masked_and_codec_d2: RTL and testbench

Unmasked-side front end and back end for the 2nd-order, three-share ISW AND gadget.
- Encoder: accepts plain operand bits over a valid/ready handshake, splits each operand into three Boolean shares using an internal LFSR, and drives the gadget's share and fresh-randomness inputs.
- Decoder: recombines the gadget's three output shares after the gadget's pipeline latency and presents the plain result through a small FIFO with valid/ready.
- Used by benches and by non-masked wrappers that need to exercise or embed the gadget.

---
 rtl/masked_and_codec_d2_if.sv | 41 ++++
 rtl/masked_and_codec_d2.sv | 137 +++++++++++++
 tb/tb_masked_and_codec_d2.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/masked_and_codec_d2_if.sv
// Plain-side handshake and gadget share wiring for masked_and_codec_d2.
// slave = codec side, master = user / gadget side.
interface masked_and_codec_d2_if;
    logic in_valid;
    logic in_ready;
    logic in_a;
    logic in_b;
    logic port_a_0;
    logic port_a_1;
    logic port_a_2;
    logic port_b_0;
    logic port_b_1;
    logic port_b_2;
    logic port_r_0;
    logic port_r_1;
    logic port_r_2;
    logic port_c_0;
    logic port_c_1;
    logic port_c_2;
    logic out_valid;
    logic out_ready;
    logic out_c;

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        input  port_c_0, port_c_1, port_c_2,
        output in_ready, out_valid, out_c,
        output port_a_0, port_a_1, port_a_2,
        output port_b_0, port_b_1, port_b_2,
        output port_r_0, port_r_1, port_r_2
    );

    modport master (
        output in_valid, in_a, in_b, out_ready,
        output port_c_0, port_c_1, port_c_2,
        input  in_ready, out_valid, out_c,
        input  port_a_0, port_a_1, port_a_2,
        input  port_b_0, port_b_1, port_b_2,
        input  port_r_0, port_r_1, port_r_2
    );
endinterface

// File: rtl/masked_and_codec_d2.sv
// Three-share encoder / decoder around a 2nd-order ISW AND gadget: LFSR masking on the
// way in, share recombination plus an in-order result FIFO on the way out.
module masked_and_codec_d2 #(
    parameter int unsigned LATENCY    = 3,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] SEED       = 32'hACE1_2C3B
) (
    input logic                   clk,
    input logic                   reset,
    masked_and_codec_d2_if.slave  bus
);
    localparam logic [31:0] TAPS    = 32'h8020_0003;
    localparam logic [31:0] SEED_NZ = (SEED == '0) ? 32'd1 : SEED;
    localparam int unsigned PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW      = $clog2(FIFO_DEPTH + 1);

    logic [31:0]   lfsr;
    logic [31:0]   lfsr_next;
    logic [6:0]    m;
    logic          accept;
    logic          pop;
    logic          enc_a;
    logic          enc_b;
    logic [2:0]    sh_a;
    logic [2:0]    sh_b;
    logic [2:0]    sh_r;
    logic [LATENCY:0] tag;
    logic          wr_en;
    logic          wr_data;
    logic [CW-1:0] occ;
    logic [CW-1:0] count;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          mem [FIFO_DEPTH];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Right-shifting Galois form: the bit shifted out feeds back through TAPS.
    always_comb begin
        lfsr_next = {1'b0, lfsr[31:1]};
        if (lfsr[0]) begin
            lfsr_next = lfsr_next ^ TAPS;
        end
    end

    assign m      = lfsr[6:0];
    assign accept = bus.in_valid && bus.in_ready;
    assign pop    = bus.out_valid && bus.out_ready;
    assign enc_a  = accept && bus.in_a;
    assign enc_b  = accept && bus.in_b;

    assign bus.in_ready = reset && (occ < CW'(FIFO_DEPTH));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr <= SEED_NZ;
        end else begin
            lfsr <= lfsr_next;
        end
    end

    // Shares are refreshed every edge; idle edges encode a zero operand.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_a <= '0;
            sh_b <= '0;
            sh_r <= '0;
        end else begin
            sh_a <= {enc_a ^ m[0] ^ m[1], m[1], m[0]};
            sh_b <= {enc_b ^ m[2] ^ m[3], m[3], m[2]};
            sh_r <= m[6:4];
        end
    end

    assign bus.port_a_0 = sh_a[0];
    assign bus.port_a_1 = sh_a[1];
    assign bus.port_a_2 = sh_a[2];
    assign bus.port_b_0 = sh_b[0];
    assign bus.port_b_1 = sh_b[1];
    assign bus.port_b_2 = sh_b[2];
    assign bus.port_r_0 = sh_r[0];
    assign bus.port_r_1 = sh_r[1];
    assign bus.port_r_2 = sh_r[2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag <= '0;
        end else begin
            tag <= {tag[LATENCY-1:0], accept};
        end
    end

    assign wr_en   = tag[LATENCY];
    assign wr_data = bus.port_c_0 ^ bus.port_c_1 ^ bus.port_c_2;

    // occ counts in-flight plus buffered results, so the FIFO can never overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ <= '0;
        end else begin
            unique case ({accept, pop})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= 1'b0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            unique case ({wr_en, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign bus.out_valid = (count != '0);
    assign bus.out_c     = mem[rd_ptr];
endmodule

// File: tb/tb_masked_and_codec_d2.sv
// Scoreboard bench for masked_and_codec_d2 with a behavioural gadget and LFSR reference.
module tb_masked_and_codec_d2;
    localparam logic [31:0] SEED = 32'hACE1_2C3B;

    typedef struct {
        bit c;
        int rdy;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   edges = 0;
    exp_t q[$];

    masked_and_codec_d2_if bus();
    masked_and_codec_d2_if bus0();

    masked_and_codec_d2 #(.LATENCY(3), .FIFO_DEPTH(4), .SEED(SEED)) u_dut (
        .clk(clk), .reset(rst_n), .bus(bus)
    );
    masked_and_codec_d2 #(.LATENCY(3), .FIFO_DEPTH(4), .SEED(32'd0)) u_dut0 (
        .clk(clk), .reset(rst_n), .bus(bus0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edges <= edges + 1;

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Reference LFSR and share encoding, straight from the masking rules.
    function automatic bit [31:0] lfsr_adv(input bit [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    function automatic bit [8:0] enc(input bit [31:0] s, input bit a, input bit b);
        bit [8:0] v;
        v[8] = s[0];
        v[7] = s[1];
        v[6] = a ^ s[0] ^ s[1];
        v[5] = s[2];
        v[4] = s[3];
        v[3] = b ^ s[2] ^ s[3];
        v[2] = s[4];
        v[1] = s[5];
        v[0] = s[6];
        return v;
    endfunction

    // Behavioural 3-stage gadget: recombine, AND, reshare with the fresh randomness.
    bit [2:0] g1, g2, g3;
    always @(posedge clk) begin
        bit p;
        p  = (bus.port_a_0 ^ bus.port_a_1 ^ bus.port_a_2) & (bus.port_b_0 ^ bus.port_b_1 ^ bus.port_b_2);
        g1 <= {p ^ bus.port_r_0 ^ bus.port_r_1, bus.port_r_1, bus.port_r_0};
        g2 <= g1;
        g3 <= g2;
    end
    assign bus.port_c_0 = g3[0];
    assign bus.port_c_1 = g3[1];
    assign bus.port_c_2 = g3[2];

    assign bus0.port_c_0 = 1'b0;
    assign bus0.port_c_1 = 1'b0;
    assign bus0.port_c_2 = 1'b0;

    // Share checker, main instance.
    bit [31:0] m_state = SEED;
    bit s_rst = 1'b0, s_a = 1'b0, s_b = 1'b0;
    always @(negedge clk) begin
        s_rst = rst_n;
        s_a   = bus.in_valid && bus.in_ready && bus.in_a;
        s_b   = bus.in_valid && bus.in_ready && bus.in_b;
    end
    always @(posedge clk) begin
        bit [8:0] want;
        #1;
        if (!s_rst) begin
            want    = '0;
            m_state = SEED;
        end else begin
            want    = enc(m_state, s_a, s_b);
            m_state = lfsr_adv(m_state);
        end
        check("shares", 32'({bus.port_a_0, bus.port_a_1, bus.port_a_2, bus.port_b_0, bus.port_b_1,
                             bus.port_b_2, bus.port_r_0, bus.port_r_1, bus.port_r_2}), 32'(want));
    end

    // Share checker, SEED=0 instance (always idle, so it exposes the raw mask stream).
    bit [31:0] m0_state = 32'd1;
    always @(posedge clk) begin
        bit [8:0] want;
        #1;
        if (!s_rst) begin
            want     = '0;
            m0_state = 32'd1;
        end else begin
            want     = enc(m0_state, 1'b0, 1'b0);
            m0_state = lfsr_adv(m0_state);
        end
        check("seed0_shares", 32'({bus0.port_a_0, bus0.port_a_1, bus0.port_a_2, bus0.port_b_0, bus0.port_b_1,
                                   bus0.port_b_2, bus0.port_r_0, bus0.port_r_1, bus0.port_r_2}), 32'(want));
    end

    // Result monitor: pops the scoreboard whenever the DUT presents a result.
    always @(negedge clk) begin
        bit exp_v;
        if (!rst_n) begin
            q.delete();
            check("rst_out_valid", 32'(bus.out_valid), 32'd0);
            check("rst_out_c", 32'(bus.out_c), 32'd0);
            check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        end else begin
            check("in_ready", 32'(bus.in_ready), 32'(q.size() < 4));
            exp_v = (q.size() > 0) && (q[0].rdy <= edges);
            check("out_valid", 32'(bus.out_valid), 32'(exp_v));
            if (exp_v && bus.out_valid) begin
                check("out_c", 32'(bus.out_c), 32'(q[0].c));
                if (bus.out_ready) void'(q.pop_front());
            end
        end
    end

    task automatic cycle(input bit v, input bit a, input bit b, input bit r, output bit acc);
        int rdy;
        bus.in_valid  = v;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.out_ready = r;
        @(negedge clk);
        acc = bus.in_valid && bus.in_ready;
        rdy = edges + 5;
        @(posedge clk);
        if (acc) q.push_back('{c: a & b, rdy: rdy});
        #2;
    endtask

    task automatic drain();
        bit acc;
        for (int i = 0; i < 60 && q.size() > 0; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, acc);
        check("drain_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        bit acc;
        int n_acc;
        bus.in_valid   = 1'b0;
        bus.in_a       = 1'b0;
        bus.in_b       = 1'b0;
        bus.out_ready  = 1'b0;
        bus0.in_valid  = 1'b0;
        bus0.in_a      = 1'b0;
        bus0.in_b      = 1'b0;
        bus0.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Truth table, back to back.
        for (int i = 0; i < 4; i++) begin
            bit [1:0] ab;
            ab = 2'(i);
            cycle(1'b1, ab[1], ab[0], 1'b1, acc);
            check("tt_accept", 32'(acc), 32'd1);
        end
        drain();

        // Random traffic with random backpressure.
        n_acc = 0;
        for (int i = 0; i < 5000 && n_acc < 1000; i++) begin
            cycle($urandom_range(3, 0) != 0, 1'($urandom), 1'($urandom), $urandom_range(3, 0) != 0, acc);
            if (acc) n_acc++;
        end
        check("random_accepts", 32'(n_acc), 32'd1000);
        drain();

        // Full backpressure: only FIFO_DEPTH ops get in.
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'($urandom), 1'($urandom), 1'b0, acc);
            if (acc) n_acc++;
        end
        check("bp_accepts", 32'(n_acc), 32'd4);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, acc);
        check("bp_full_reject", 32'(acc), 32'd0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, acc);
        check("bp_refill", 32'(acc), 32'd1);
        repeat (3) cycle(1'b1, 1'($urandom), 1'($urandom), 1'b1, acc);
        drain();

        // Reset while three operations are in flight.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1, 1'b1, acc);
        rst_n = 1'b0;
        cycle(1'b0, 1'b0, 1'b0, 1'b1, acc);
        rst_n = 1'b1;
        repeat (12) cycle(1'b0, 1'b0, 1'b0, 1'b1, acc);
        check("post_reset_empty", 32'(q.size()), 32'd0);

        // Long idle run exercises the SEED=0 instance over 2^16 cycles.
        repeat (66000) cycle(1'b0, 1'b0, 1'b0, 1'b1, acc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
